// File: rtl/sseg_scan.sv
// Multiplexed D-digit common-anode seven-segment scanner with double-buffered
// loading, per-digit dp/blank, leading-zero blanking and PWM brightness.
module sseg_scan #(
    parameter int unsigned D  = 4,
    parameter int unsigned N  = 16,
    parameter int unsigned BW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4*D-1:0]  in,
    input  logic [D-1:0]    dp,
    input  logic [D-1:0]    blank,
    input  logic            load,
    input  logic            lzb,
    input  logic [BW-1:0]   bright,
    output logic [7:0]      c,
    output logic [D-1:0]    an,
    output logic            frame
);

    localparam int unsigned IW = $clog2(D);
    localparam int unsigned DW = 4 * D;

    logic [N-1:0]  presc;
    logic [IW-1:0] idx;
    logic [DW-1:0] pend_in,    act_in;
    logic [D-1:0]  pend_dp,    act_dp;
    logic [D-1:0]  pend_blank, act_blank;
    logic          pend_valid;

    logic          wrap_c;
    logic          boundary_c;
    logic [3:0]    nib_c;
    logic          dp_c;
    logic          blank_c;
    logic          supp_c;
    logic          zrun_c;
    logic          lit_c;
    logic [7:0]    c_c;
    logic [D-1:0]  an_c;

    // Active-low g..a pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h27;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign wrap_c     = (presc == '1);
    assign boundary_c = wrap_c && (idx == IW'(D - 1));

    // Select the current digit; zrun_c walks down from the top digit so that at
    // digit k it says whether digits k..D-1 are all zero with no dp.
    always_comb begin
        nib_c   = 4'h0;
        dp_c    = 1'b0;
        blank_c = 1'b0;
        supp_c  = 1'b0;
        zrun_c  = 1'b1;
        for (int k = int'(D) - 1; k >= 0; k--) begin
            zrun_c = zrun_c && (act_in[4*k +: 4] == 4'h0) && !act_dp[k];
            if (idx == IW'(k)) begin
                nib_c   = act_in[4*k +: 4];
                dp_c    = act_dp[k];
                blank_c = act_blank[k];
                supp_c  = lzb && (k != 0) && zrun_c;
            end
        end
    end

    assign lit_c = !blank_c && !supp_c && (presc[N-1 -: BW] < bright);
    assign an_c  = lit_c ? ~(D'(1) << idx) : '1;
    assign c_c   = lit_c ? {~dp_c, hex7(nib_c)} : 8'hFF;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            pend_in    <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            act_in     <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            c          <= 8'hFF;
            an         <= '1;
            frame      <= 1'b0;
        end else begin
            presc <= presc + N'(1);
            if (wrap_c) begin
                idx <= boundary_c ? '0 : idx + IW'(1);
            end
            // Boundary promotes the old pending value; a coincident load refills pending.
            if (boundary_c && pend_valid) begin
                act_in    <= pend_in;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
            if (load) begin
                pend_in    <= in;
                pend_dp    <= dp;
                pend_blank <= blank;
            end
            pend_valid <= load || (pend_valid && !boundary_c);
            c          <= c_c;
            an         <= an_c;
            frame      <= boundary_c;
        end
    end

endmodule

// File: tb/tb_sseg_scan.sv
// Directed bench for sseg_scan: a D=4/N=4/BW=2 instance and a D=8/N=3/BW=2 instance.
module tb_sseg_scan;

    logic        clk = 1'b0;
    logic        rst_n, load, lzb;
    logic [15:0] in;
    logic [3:0]  dp, blank, an;
    logic [1:0]  bright;
    logic [7:0]  c;
    logic        frame;

    logic        rst_n8, load8, lzb8;
    logic [31:0] in8;
    logic [7:0]  dp8, blank8, an8, c8;
    logic [1:0]  bright8;
    logic        frame8;

    int checks = 0;
    int errors = 0;
    int t = 0;
    int n;

    always #5 clk = ~clk;

    sseg_scan #(.D(4), .N(4), .BW(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .in(in), .dp(dp), .blank(blank), .load(load),
        .lzb(lzb), .bright(bright), .c(c), .an(an), .frame(frame)
    );

    sseg_scan #(.D(8), .N(3), .BW(2)) dut8 (
        .clk(clk), .rst_n(rst_n8), .in(in8), .dp(dp8), .blank(blank8), .load(load8),
        .lzb(lzb8), .bright(bright8), .c(c8), .an(an8), .frame(frame8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        t++;
        chk("an4_onehot", 32'($countones(~an) <= 1), 32'd1);
        chk("an8_onehot", 32'($countones(~an8) <= 1), 32'd1);
    endtask

    task automatic go_to(input int j);
        while (t < j) cyc();
    endtask

    task automatic dig(input string tag, input int j, input logic [3:0] ea, input logic [7:0] ec);
        go_to(j);
        chk({tag, "_an"}, 32'(an), 32'(ea));
        chk({tag, "_c"}, 32'(c), 32'(ec));
    endtask

    task automatic dig8(input string tag, input int j, input logic [7:0] ea, input logic [7:0] ec);
        go_to(j);
        chk({tag, "_an8"}, 32'(an8), 32'(ea));
        chk({tag, "_c8"}, 32'(c8), 32'(ec));
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; lzb = 1'b0; in = '0; dp = '0; blank = '0; bright = 2'd3;
        rst_n8 = 1'b0; load8 = 1'b0; lzb8 = 1'b0; in8 = '0; dp8 = '0; blank8 = '0; bright8 = 2'd3;
        repeat (3) cyc();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_c", 32'(c), 32'hFF);
        chk("rst_frame", 32'(frame), 32'd0);

        rst_n = 1'b1; t = 0;
        in = 16'h12AF; load = 1'b1;
        cyc(); load = 1'b0;
        dig("f1_d0", 1, 4'hE, 8'hC0);
        dig("f1_dark", 13, 4'hF, 8'hFF);
        dig("f1_d1", 17, 4'hD, 8'hC0);
        go_to(63); chk("frame_lo", 32'(frame), 32'd0);
        go_to(64); chk("frame_hi", 32'(frame), 32'd1);
        dig("f2_d0", 65, 4'hE, 8'h8E);
        chk("frame_one", 32'(frame), 32'd0);
        dig("f2_d1", 81, 4'hD, 8'h88);
        dig("f2_d2", 97, 4'hB, 8'hA4);
        dig("f2_d3", 113, 4'h7, 8'hF9);
        go_to(127); chk("frame_lo2", 32'(frame), 32'd0);
        go_to(128); chk("frame_hi2", 32'(frame), 32'd1);

        bright = 2'd1;
        dig("b1_first", 129, 4'hE, 8'h8E);
        dig("b1_last", 132, 4'hE, 8'h8E);
        dig("b1_off", 133, 4'hF, 8'hFF);
        dig("b1_off2", 144, 4'hF, 8'hFF);
        n = 0;
        repeat (16) begin cyc(); if (an == 4'hD && c == 8'h88) n++; end
        chk("b1_duty", 32'(n), 32'd4);

        bright = 2'd0;
        n = 0;
        repeat (192) begin cyc(); if (an != 4'hF || c != 8'hFF) n++; end
        chk("b0_dark", 32'(n), 32'd0);

        bright = 2'd3; lzb = 1'b1; in = 16'h0050; dp = 4'b0000; load = 1'b1;
        cyc(); load = 1'b0;
        dig("lzb_d0", 385, 4'hE, 8'hC0);
        dig("lzb_d1", 401, 4'hD, 8'h92);
        dig("lzb_d2", 417, 4'hF, 8'hFF);
        dig("lzb_d3", 433, 4'hF, 8'hFF);
        go_to(448);
        dp = 4'b0100; load = 1'b1;
        cyc(); load = 1'b0;
        dig("lzbdp_d0", 513, 4'hE, 8'hC0);
        dig("lzbdp_d1", 529, 4'hD, 8'h92);
        dig("lzbdp_d2", 545, 4'hB, 8'h40);
        dig("lzbdp_d3", 561, 4'hF, 8'hFF);

        go_to(576);
        lzb = 1'b0; dp = 4'b0000; in = 16'h1111; load = 1'b1;
        cyc(); load = 1'b0;
        go_to(600);
        in = 16'h2222; load = 1'b1;
        cyc(); load = 1'b0;
        dig("tear_d0", 641, 4'hE, 8'hA4);
        dig("tear_d1", 657, 4'hD, 8'hA4);
        dig("tear_d2", 673, 4'hB, 8'hA4);
        dig("tear_d3", 689, 4'h7, 8'hA4);

        go_to(690);
        in = 16'h4444; load = 1'b1;
        cyc(); load = 1'b0;
        go_to(703);
        in = 16'h3333; load = 1'b1;
        cyc(); load = 1'b0;
        chk("coinc_frame", 32'(frame), 32'd1);
        dig("coinc_old_d0", 705, 4'hE, 8'h99);
        dig("coinc_old_d1", 721, 4'hD, 8'h99);
        dig("coinc_new_d0", 769, 4'hE, 8'hB0);
        dig("coinc_new_d2", 801, 4'hB, 8'hB0);

        go_to(850);
        in = 16'h5555; load = 1'b1;
        cyc(); load = 1'b0;
        dig("pre_rst_d2", 868, 4'hB, 8'hB0);
        rst_n = 1'b0;
        cyc();
        chk("mrst_an", 32'(an), 32'hF);
        chk("mrst_c", 32'(c), 32'hFF);
        chk("mrst_frame", 32'(frame), 32'd0);
        rst_n = 1'b1; t = 0;
        dig("mrst_f1_d0", 1, 4'hE, 8'hC0);
        dig("mrst_f1_d1", 17, 4'hD, 8'hC0);
        dig("mrst_f2_d0", 65, 4'hE, 8'hC0);
        dig("mrst_f2_d2", 97, 4'hB, 8'hC0);

        go_to(100);
        rst_n8 = 1'b1; t = 0;
        in8 = 32'h76543210; blank8 = 8'h81; load8 = 1'b1;
        cyc(); load8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] one;
            one = 8'd1;
            dig8("walk", 1 + 8*k, ~(one << k), 8'hC0);
        end
        go_to(63); chk("f8_lo", 32'(frame8), 32'd0);
        go_to(64); chk("f8_hi", 32'(frame8), 32'd1);
        dig8("blk_d0", 65, 8'hFF, 8'hFF);
        dig8("blk_d1", 73, 8'hFD, 8'hF9);
        dig8("blk_d2", 81, 8'hFB, 8'hA4);
        dig8("blk_d6", 113, 8'hBF, 8'h82);
        dig8("blk_d7", 121, 8'hFF, 8'hFF);
        go_to(127); chk("f8_lo2", 32'(frame8), 32'd0);
        go_to(128); chk("f8_hi2", 32'(frame8), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
